// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame states, width and mode constants
package spi_pkg;
   localparam int SPI_WIDTH = 8;
   localparam bit SPI_CPOL  = 1'b0;
   localparam bit SPI_CPHA  = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE_HI,
      ST_PRE_LO,
      ST_SEL,
      ST_BIT_HI,
      ST_BIT_LO,
      ST_DESEL,
      ST_POST_LO
   } spi_state_e;
endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - loadable down-counter marking the last clk of each sclk phase
module spi_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_l,
   input  logic i_load,
   output logic o_phase_end
);
   logic [7:0] r_cnt;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= 8'(CLK_DIV - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   assign o_phase_end = (r_cnt == '0);
endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master with preamble pulse and trailing sclk fall
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int WIDTH   = SPI_WIDTH
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy,
   output logic             done,
   output logic             ss_l,
   output logic             sclk,
   output logic             mosi,
   input  logic             miso
);
   localparam int BIT_W = $clog2(WIDTH);

   spi_state_e       r_state;
   logic [WIDTH-1:0] r_tx;
   logic [WIDTH-1:0] r_rx;
   logic [WIDTH-1:0] r_rx_data;
   logic [BIT_W-1:0] r_bit;
   logic             r_busy, r_done, r_ss_l, r_sclk, r_mosi;
   logic             w_phase_end, w_load;

   // The timer reloads on every phase change; leaving POST_LO lets it park at 0.
   assign w_load = ((r_state == ST_IDLE) && start) ||
                   ((r_state != ST_IDLE) && (r_state != ST_POST_LO) && w_phase_end);

   spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk        (clk),
      .rst_l      (rst_l),
      .i_load     (w_load),
      .o_phase_end(w_phase_end)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state   <= ST_IDLE;
         r_tx      <= '0;
         r_rx      <= '0;
         r_rx_data <= '0;
         r_bit     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ss_l    <= 1'b1;
         r_sclk    <= SPI_CPOL;
         r_mosi    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: if (start) begin
               r_state <= ST_PRE_HI;
               r_tx    <= tx_data;
               r_bit   <= '0;
               r_busy  <= 1'b1;
               r_sclk  <= 1'b1;
            end
            ST_PRE_HI: if (w_phase_end) begin
               r_state <= ST_PRE_LO;
               r_sclk  <= 1'b0;
            end
            ST_PRE_LO: if (w_phase_end) begin
               r_state <= ST_SEL;
               r_ss_l  <= 1'b0;
               r_mosi  <= r_tx[WIDTH-1];
            end
            ST_SEL: if (w_phase_end) begin
               r_state <= ST_BIT_HI;
               r_sclk  <= 1'b1;
            end
            ST_BIT_HI: if (w_phase_end) begin
               r_rx <= {r_rx[WIDTH-2:0], miso};
               if (r_bit == BIT_W'(WIDTH - 1)) begin
                  r_state <= ST_DESEL;
                  r_ss_l  <= 1'b1;
               end else begin
                  r_state <= ST_BIT_LO;
                  r_sclk  <= 1'b0;
                  r_mosi  <= r_tx[WIDTH-2];
                  r_tx    <= {r_tx[WIDTH-2:0], 1'b0};
                  r_bit   <= r_bit + BIT_W'(1);
               end
            end
            ST_BIT_LO: if (w_phase_end) begin
               r_state <= ST_BIT_HI;
               r_sclk  <= 1'b1;
            end
            ST_DESEL: if (w_phase_end) begin
               r_state <= ST_POST_LO;
               r_sclk  <= 1'b0;
               r_mosi  <= 1'b0;
            end
            ST_POST_LO: if (w_phase_end) begin
               r_state   <= ST_IDLE;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_rx_data <= r_rx;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rx_data = r_rx_data;
   assign busy    = r_busy;
   assign done    = r_done;
   assign ss_l    = r_ss_l;
   assign sclk    = r_sclk;
   assign mosi    = r_mosi;
endmodule
